// File: rtl/vga_pkg.sv
// Shared VGA timing constants, source-image geometry and zoom-code decoding.
// Imported by the frame reader and by the upstream scaler so both agree on geometry.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int LARGURA_ORIG = 160;
    localparam int ALTURA_ORIG  = 120;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        ZOOM_1X       = 2'b00,
        ZOOM_2X       = 2'b01,
        ZOOM_4X       = 2'b10,
        ZOOM_4X_CLAMP = 2'b11
    } zoom_code_t;

    // Scale is held as log2 so the window size is a shift of the source size.
    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_t;

    function automatic scale_t zoom_to_scale(input logic [1:0] code);
        scale_t result;
        case (zoom_code_t'(code))
            ZOOM_1X: result = SCALE_1X;
            ZOOM_2X: result = SCALE_2X;
            default: result = SCALE_4X;
        endcase
        return result;
    endfunction

    function automatic int scale_factor(input scale_t s);
        return 1 << int'(s);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port, zoom control and video outputs of the frame reader.
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic [1:0]        zoom_select;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_data;
    logic              hsync;
    logic              vsync;
    logic [PIX_W-1:0]  pixel_out;
    logic              blank_n;
    logic              frame_start;
    logic              vblank;

    modport master (
        input  zoom_select, ram_data,
        output ram_addr, hsync, vsync, pixel_out, blank_n, frame_start, vblank
    );

    modport slave (
        output zoom_select, ram_data,
        input  ram_addr, hsync, vsync, pixel_out, blank_n, frame_start, vblank
    );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw (undelayed) sync and visible decode.
module vga_timing #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic                     running,
    output logic                     frame_start,
    output logic                     frame_end,
    output logic                     hsync_raw,
    output logic                     vsync_raw,
    output logic                     visible_raw,
    output logic                     vblank_raw
);
    import vga_pkg::*;

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int H_LAST       = H_SYNC_END + H_BACK - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int V_LAST       = V_SYNC_END + V_BACK - 1;

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    always_comb begin
        h_next = h_cnt + CNT_W'(1);
        v_next = v_cnt;
        if (h_cnt == CNT_W'(H_LAST)) begin
            h_next = '0;
            v_next = (v_cnt == CNT_W'(V_LAST)) ? '0 : v_cnt + CNT_W'(1);
        end
    end

    // The first clock after reset only arms the raster, so frame_start is
    // high exactly while the counters sit at (0,0) for the first time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            running     <= 1'b0;
            frame_start <= 1'b0;
        end else if (!running) begin
            running     <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            frame_start <= (h_next == '0) && (v_next == '0);
        end
    end

    always_comb begin
        hsync_raw   = 1'b1;
        vsync_raw   = 1'b1;
        visible_raw = 1'b0;
        vblank_raw  = 1'b0;
        frame_end   = 1'b0;
        if (running) begin
            hsync_raw   = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
            vsync_raw   = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
            visible_raw = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
            vblank_raw  = (v_cnt >= CNT_W'(V_VISIBLE));
            frame_end   = (h_cnt == CNT_W'(H_LAST)) && (v_cnt == CNT_W'(V_LAST));
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out of a scaled, centred framebuffer image: window/address generation
// and two-stage alignment of sync, blanking and pixel data with a synchronous RAM.
module vga_frame_reader #(
    parameter int H_VISIBLE    = vga_pkg::H_VISIBLE,
    parameter int V_VISIBLE    = vga_pkg::V_VISIBLE,
    parameter int LARGURA_ORIG = vga_pkg::LARGURA_ORIG,
    parameter int ALTURA_ORIG  = vga_pkg::ALTURA_ORIG
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_reader_if.master bus
);
    import vga_pkg::*;

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              running;
    logic              frame_start;
    logic              frame_end;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              visible_raw;
    logic              vblank_raw;

    scale_t            scale;
    logic [ADDR_W-1:0] pix_idx;
    logic              in_window;
    int                win_w;
    int                win_h;
    int                x0;
    int                y0;

    logic              hsync_s1;
    logic              vsync_s1;
    logic              blank_s1;
    logic              vblank_s1;
    logic              win_s1;
    logic              win_s2;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .running     (running),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible_raw (visible_raw),
        .vblank_raw  (vblank_raw)
    );

    assign bus.frame_start = frame_start;

    // Zoom is sampled only on the last raster position so a frame never changes size mid-scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale <= SCALE_1X;
        end else if (frame_end) begin
            scale <= zoom_to_scale(bus.zoom_select);
        end
    end

    always_comb begin
        win_w     = LARGURA_ORIG * scale_factor(scale);
        win_h     = ALTURA_ORIG * scale_factor(scale);
        x0        = (H_VISIBLE - win_w) / 2;
        y0        = (V_VISIBLE - win_h) / 2;
        in_window = running
                    && (int'(h_cnt) >= x0) && (int'(h_cnt) < x0 + win_w)
                    && (int'(v_cnt) >= y0) && (int'(v_cnt) < y0 + win_h);
    end

    // Raster order inside the window is row-major, so counting window pixels
    // yields (v-Y0)*W + (h-X0) without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_idx <= '0;
        end else if (frame_end) begin
            pix_idx <= '0;
        end else if (in_window) begin
            pix_idx <= pix_idx + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_addr <= '0;
            hsync_s1     <= 1'b1;
            vsync_s1     <= 1'b1;
            blank_s1     <= 1'b0;
            vblank_s1    <= 1'b0;
            win_s1       <= 1'b0;
        end else begin
            bus.ram_addr <= in_window ? pix_idx : '0;
            hsync_s1     <= hsync_raw;
            vsync_s1     <= vsync_raw;
            blank_s1     <= visible_raw;
            vblank_s1    <= vblank_raw;
            win_s1       <= in_window;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hsync   <= 1'b1;
            bus.vsync   <= 1'b1;
            bus.blank_n <= 1'b0;
            bus.vblank  <= 1'b0;
            win_s2      <= 1'b0;
        end else begin
            bus.hsync   <= hsync_s1;
            bus.vsync   <= vsync_s1;
            bus.blank_n <= blank_s1;
            bus.vblank  <= vblank_s1;
            win_s2      <= win_s1;
        end
    end

    // ram_data already leaves the RAM's output register in this stage; only the window mask is applied here.
    assign bus.pixel_out = win_s2 ? bus.ram_data : '0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster (32x24 visible, 8x6 source).
module tb_vga_frame_reader;

    localparam int TB_HV   = 32;
    localparam int TB_VV   = 24;
    localparam int TB_LW   = 8;
    localparam int TB_LH   = 6;
    localparam int H_LINE  = TB_HV + 16 + 96 + 48;
    localparam int V_LINES = TB_VV + 10 + 2 + 33;
    localparam int FRAME   = H_LINE * V_LINES;

    typedef struct packed {
        logic        frame_start;
        logic [18:0] ram_addr;
        logic        hsync;
        logic        vsync;
        logic        blank_n;
        logic        vblank;
        logic [7:0]  pixel;
    } out_t;

    typedef struct {
        bit valid;
        int h;
        int v;
        int s;
    } pos_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] mem [1024];

    out_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   k = -1;
    int   cur_scale = 1;
    int   next_scale = 1;
    pos_t cur, p1, p2;

    vga_frame_reader_if bus ();

    vga_frame_reader #(
        .H_VISIBLE    (TB_HV),
        .V_VISIBLE    (TB_VV),
        .LARGURA_ORIG (TB_LW),
        .ALTURA_ORIG  (TB_LH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    always @(posedge clk) bus.ram_data <= mem[bus.ram_addr[9:0]];

    function automatic bit in_win(pos_t p);
        int w, h, x0, y0;
        w  = TB_LW * p.s;
        h  = TB_LH * p.s;
        x0 = (TB_HV - w) / 2;
        y0 = (TB_VV - h) / 2;
        return p.valid && p.h >= x0 && p.h < x0 + w && p.v >= y0 && p.v < y0 + h;
    endfunction

    function automatic int addr_of(pos_t p);
        int w, h, x0, y0;
        w  = TB_LW * p.s;
        h  = TB_LH * p.s;
        x0 = (TB_HV - w) / 2;
        y0 = (TB_VV - h) / 2;
        return in_win(p) ? (p.v - y0) * w + (p.h - x0) : 0;
    endfunction

    function automatic out_t expected(pos_t c, pos_t a1, pos_t a2);
        out_t e;
        e.frame_start = c.valid && c.h == 0 && c.v == 0;
        e.ram_addr    = 19'(addr_of(a1));
        e.hsync       = 1'b1;
        e.vsync       = 1'b1;
        e.blank_n     = 1'b0;
        e.vblank      = 1'b0;
        e.pixel       = 8'h00;
        if (a2.valid) begin
            e.hsync   = !(a2.h >= TB_HV + 16 && a2.h < TB_HV + 16 + 96);
            e.vsync   = !(a2.v >= TB_VV + 10 && a2.v < TB_VV + 12);
            e.blank_n = a2.h < TB_HV && a2.v < TB_VV;
            e.vblank  = a2.v >= TB_VV;
            e.pixel   = in_win(a2) ? mem[addr_of(a2)] : 8'h00;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    endtask

    // One clock of stimulus: drive rst/zoom for this cycle and queue what the outputs must be.
    task automatic applyStimulus(input logic rst_v, input logic [1:0] zoom_v);
        int j;
        @(posedge clk);
        #1;
        rst = rst_v;
        bus.zoom_select = zoom_v;
        if (rst_v) begin
            k = -1;
            cur_scale = 1;
            next_scale = 1;
            cur.valid = 0;
            p1.valid = 0;
            p2.valid = 0;
        end else begin
            k++;
            p2 = p1;
            p1 = cur;
            cur.valid = 0;
            if (k >= 1) begin
                j = k - 1;
                if (j % FRAME == 0 && j > 0) cur_scale = next_scale;
                cur.valid = 1;
                cur.h = j % H_LINE;
                cur.v = (j % FRAME) / H_LINE;
                cur.s = cur_scale;
                if (j % FRAME == FRAME - 1)
                    next_scale = (zoom_v == 2'b00) ? 1 : (zoom_v == 2'b01) ? 2 : 4;
            end
        end
        exp_q.push_back(expected(cur, p1, p2));
    endtask

    // Monitor: pops one expectation per clock and also measures frame-level timing.
    initial begin
        out_t e, a;
        int cyc = 0, last_fs = -1, vs_low = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.frame_start, bus.ram_addr, bus.hsync, bus.vsync,
                     bus.blank_n, bus.vblank, bus.pixel_out};
                checkOutput("outputs", 64'(a), 64'(e));
            end
            if (rst) begin
                last_fs = -1;
                vs_low = 0;
            end else begin
                if (bus.frame_start) begin
                    if (last_fs >= 0) begin
                        checkOutput("frame_period", 64'(cyc - last_fs), 64'(FRAME));
                        checkOutput("vsync_low_clks", 64'(vs_low), 64'(2 * H_LINE));
                    end
                    last_fs = cyc;
                    vs_low = 0;
                end
                if (!bus.vsync) vs_low++;
            end
        end
    end

    initial begin
        logic [1:0] plan [3];
        logic [1:0] rz;
        int hold, run_len;
        plan[0] = 2'b01;
        plan[1] = 2'b11;
        plan[2] = 2'b10;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        bus.zoom_select = 2'b00;
        cur.valid = 0;
        p1.valid = 0;
        p2.valid = 0;
        $display("[TB] start: %0d clk per frame", FRAME);

        repeat (4) applyStimulus(1'b1, 2'b00);
        applyStimulus(1'b0, 2'b00);

        // Random zoom churn mid-frame; only the value held at the frame's last clock matters.
        for (int f = 0; f < 3; f++) begin
            hold = $urandom_range(1, 2000);
            rz = 2'($urandom_range(0, 3));
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 499) == 0) rz = 2'($urandom_range(0, 3));
                applyStimulus(1'b0, (c >= FRAME - hold) ? plan[f] : rz);
            end
        end

        run_len = $urandom_range(2 * H_LINE, 10 * H_LINE);
        for (int c = 0; c < run_len; c++) applyStimulus(1'b0, 2'($urandom_range(0, 3)));
        repeat (3) applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        for (int c = 0; c < 3000; c++) applyStimulus(1'b0, 2'($urandom_range(0, 3)));

        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-003 Parameter LARGURA_ORIG, default 160: source image width.
REQ-004 Parameter ALTURA_ORIG, default 120: source image height.
REQ-005 clk  input  1  25 MHz pixel clock.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 zoom_select  input  2  scale code: 00=1x, 01=2x, 10=4x, 11=4x (clamped).
REQ-008 ram_addr  output  19  framebuffer read address.
REQ-009 ram_data  input  8  framebuffer read data, valid exactly 1 clk after ram_addr (synchronous RAM).
REQ-010 hsync  output  1  horizontal sync, active-low.
REQ-011 vsync  output  1  vertical sync, active-low.
REQ-012 pixel_out  output  8  grayscale pixel to the DAC; 0 when blanked or outside the image window.
REQ-013 blank_n  output  1  high while in the visible 640x480 area.
REQ-014 frame_start  output  1  1-clk pulse at h=0, v=0 (counter stage).
REQ-015 vblank  output  1  high while v_cnt >= 480; upstream scaler writes only while this is high.

Function
REQ-016 h_cnt SHALL count 0..799 and wrap; v_cnt SHALL increment when h_cnt wraps, counting 0..524 and wrapping.
REQ-017 Horizontal timing: visible 0-639, front porch 640-655, sync 656-751 (hsync=0), back porch 752-799.
REQ-018 Vertical timing: visible 0-479, front porch 480-489, sync 490-491 (vsync=0), back porch 492-524.
REQ-019 Scale s SHALL be latched from zoom_select only on the cycle h_cnt=799, v_cnt=524; mid-frame changes SHALL take effect the following frame.
REQ-020 Window W=LARGURA_ORIG*s, H=ALTURA_ORIG*s; offsets X0=(640-W)/2, Y0=(480-H)/2 (s=1: 240,180; s=2: 160,120; s=4: 0,0).
REQ-021 Inside the window (X0<=h<X0+W, Y0<=v<Y0+H): ram_addr SHALL be (v-Y0)*W+(h-X0), registered 1 clk after the counter value; the maximum of 307199 fits 19 bits.
REQ-022 Outside the window: ram_addr SHALL be 0 and the pixel SHALL be forced to 0.
REQ-023 Pipeline: hsync, vsync, blank_n, pixel_out and vblank SHALL all correspond to the counter value from 2 clk earlier; frame_start SHALL be aligned with the counter stage.
REQ-024 The address sequence inside the window SHALL be strictly consecutive row-major with no gaps, matching the scaler's write order.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst: h_cnt=0, v_cnt=0, s=1, ram_addr=0, pixel_out=0, blank_n=0, hsync=1, vsync=1, frame_start=0, vblank=0, and all pipeline stages cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; after release, counting SHALL restart at (0,0) and frame_start SHALL pulse on the first clk.

Structure
REQ-028 Shared package vga_pkg SHALL hold the timing constants (visible, porch, sync, total per axis), LARGURA_ORIG, ALTURA_ORIG and the zoom-code-to-scale mapping; the scaler SHALL import the same constants.
REQ-029 One sub-module, vga_timing, SHALL contain the h/v counters and raw sync/visible decode; vga_frame_reader SHALL add window/address logic and pipeline alignment.
REQ-030 Target size: 150-300 lines RTL.

Verification
REQ-031 Free-run 2 frames after reset -> 800 clk per line, 525 lines; hsync low 96 clk per line; vsync low for exactly 1600 clk; frame_start period 420000 clk.
REQ-032 zoom=10, RAM model returns addr[7:0] -> first visible pixel (h=0,v=0) is 0x00; pixel (639,479) is 307199[7:0]=0xFF; last ram_addr in the frame is 307199.
REQ-033 zoom=00 -> blank_n high but pixel_out=0 at (239,180); ram_addr=0 at (240,180) and 159 at (399,180); pixel_out=0 at (400,180).
REQ-034 Change zoom 00->01 at v=200 -> current frame keeps W=160; next frame window starts at (160,120) with W=320.
REQ-035 zoom=11 -> behaviour identical to zoom=10 (full-screen 640x480).
REQ-036 Assert rst at h=300, v=100 for 3 clk -> outputs at reset values during rst; frame_start at the first clk after release; hsync falls 656 clk later, aligned per REQ-023.
